rgb_pattern_checker: RTL and testbench
======================================

# rgb_pattern_checker

Parametrised multi-channel RGB test-pattern checker for the LVDS receive path, placed after channel deskew and before the display pipeline. Each beat carries CHANNELS pixels, checked against one of three patterns: grayscale, incrementing gray ramp, or fixed reference colour. A lock state machine, a saturating error counter, a sticky error flag and per-frame error reporting replace the single combinational grayscale flag of the previous generation.

## Interface
- CHANNELS, 2, pixels per beat (1..4)
- COLOR_W, 8, bits per colour component
- ERR_CNT_W, 16, error counter width
- LOCK_GOOD, 16, consecutive good beats to enter LOCKED (>=1)
- LOCK_BAD, 4, consecutive bad beats to leave LOCKED (>=1)

- I_clk  in  1  pixel clock
- I_rst_n  in  1  asynchronous reset, active low
- I_vs  in  1  frame-start pulse, one cycle
- I_de  in  1  beat valid
- I_mode  in  2  0 gray, 1 ramp, 2 fixed, 3 reserved (treated as gray); sampled on I_vs
- I_ref_rgb  in  3*COLOR_W  fixed-mode reference {R,G,B}; sampled on I_vs
- I_clr  in  1  synchronous clear of counter and sticky flag
- I_rgb_data  in  CHANNELS*3*COLOR_W  channel c at [(c+1)*3*COLOR_W-1 : c*3*COLOR_W], each {R,G,B}
- O_pix_ok  out  CHANNELS  per-channel pass for the checked beat
- O_beat_vld  out  1  qualifies O_pix_ok
- O_lock  out  1  FSM in LOCKED
- O_err_cnt  out  ERR_CNT_W  bad beats counted while LOCKED, saturating
- O_sticky_err  out  1  set by any counted bad beat
- O_frame_err  out  1  one-cycle pulse at frame boundary if previous frame had a counted bad beat

## Operation
- Stage 1 registers I_de, I_vs, I_rgb_data; I_vs also latches I_mode and I_ref_rgb into active registers.
- Stage 2 compares and registers O_pix_ok, O_beat_vld.
- Gray: channel ok iff R==G==B.
- Fixed: channel ok iff {R,G,B} == active reference.
- Ramp: gray required, and channel c R == channel 0 R + c (mod 2^COLOR_W); across beats channel 0 R == previous beat channel 0 R + CHANNELS (mod 2^COLOR_W). The first valid beat after I_vs or after leaving LOCKED is a seed: continuity not checked, gray and intra-beat still checked.
- Beat good iff all O_pix_ok bits set.
- FSM SEARCH: count consecutive good beats; reaching LOCK_GOOD -> LOCKED; a bad beat restarts the count at 0.
- FSM LOCKED: count consecutive bad beats; reaching LOCK_BAD -> SEARCH; a good beat restarts the count at 0.
- Beats with I_de low neither advance nor reset FSM counts.
- Counted bad beat = bad beat while LOCKED (including the one causing the exit): O_err_cnt +1, saturating at all-ones; O_sticky_err set.
- I_clr and a counted bad beat in the same cycle: clear wins; counter 0, sticky 0.
- I_vs: mode/reference update; FSM state unchanged; ramp reseeded.

## Timing
- Reset: O_pix_ok 0, O_beat_vld 0, O_lock 0, O_err_cnt 0, O_sticky_err 0, O_frame_err 0, FSM SEARCH, active mode gray, reference 0.
- O_pix_ok/O_beat_vld: 2 cycles after the input beat.
- O_lock, O_err_cnt, O_sticky_err: 3 cycles after the deciding beat.
- O_frame_err: 3 cycles after I_vs.
- Mode change takes effect on the beat presented with I_vs and later beats.
- Reset mid-frame: all state cleared immediately; next beat is a seed.

## Configuration
- RGB_CHK_FRAME_STAT_EN defined: per-frame error tracking and O_frame_err as specified.
- Not defined: no frame tracking logic; O_frame_err tied 0; all other behaviour identical.

## Test plan
- CHANNELS=2, gray mode, 20 beats {R,G,B}={0x55,0x55,0x55} -> O_lock rises 3 cycles after beat 16; O_err_cnt 0.
- Locked, one beat with channel 1 = {0x55,0x54,0x55} -> O_pix_ok=2'b01; O_err_cnt 1; O_sticky_err 1; O_lock stays 1.
- Ramp mode, channel 0 R = 0xFE, channel 1 0xFF, next beat 0x00, 0x01 -> all beats pass (wrap at 2^8).
- Locked, 4 consecutive bad beats -> O_lock falls; O_err_cnt +4; next good beat is a seed; no continuity error reported.
- ERR_CNT_W=2, 5 counted bad beats -> O_err_cnt holds 3; I_clr asserted together with a bad beat -> O_err_cnt 0, O_sticky_err 0.
- Macro defined, bad beat in frame N, then I_vs -> O_frame_err pulses for 1 cycle, 3 cycles after I_vs; clean frame N+1 -> no pulse.

Source files
------------

// File: rtl/rgb_pattern_checker.sv
// Multi-channel RGB test-pattern checker (gray / ramp / fixed colour) with lock FSM and error statistics; RGB_CHK_FRAME_STAT_EN adds per-frame error pulse.
// Latency: O_pix_ok/O_beat_vld 2 cycles after the beat; O_lock, O_err_cnt, O_sticky_err, O_frame_err 3 cycles after the beat / I_vs.
// No backpressure: one beat accepted every cycle I_de is high; I_clr travels with the data so it lines up with the beat it was presented with.
module rgb_pattern_checker #(
  parameter int CHANNELS  = 2,
  parameter int COLOR_W   = 8,
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_GOOD = 16,
  parameter int LOCK_BAD  = 4
) (
  input  logic                            I_clk,
  input  logic                            I_rst_n,
  input  logic                            I_vs,
  input  logic                            I_de,
  input  logic [1:0]                      I_mode,
  input  logic [3*COLOR_W-1:0]            I_ref_rgb,
  input  logic                            I_clr,
  input  logic [CHANNELS*3*COLOR_W-1:0]   I_rgb_data,
  output logic [CHANNELS-1:0]             O_pix_ok,
  output logic                            O_beat_vld,
  output logic                            O_lock,
  output logic [ERR_CNT_W-1:0]            O_err_cnt,
  output logic                            O_sticky_err,
  output logic                            O_frame_err
);

  localparam int PIX_W  = 3 * COLOR_W;
  localparam int CNT_MX = (LOCK_GOOD > LOCK_BAD) ? LOCK_GOOD : LOCK_BAD;
  localparam int CNT_W  = $clog2(CNT_MX + 1);

  localparam logic [1:0] MODE_GRAY  = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_FIXED = 2'd2;

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_e;

  // stage 1
  logic                       de_s1_q, vs_s1_q, clr_s1_q;
  logic [CHANNELS*PIX_W-1:0]  rgb_s1_q;
  logic [1:0]                 mode_q;
  logic [PIX_W-1:0]           ref_q;
  // stage 2
  logic [CHANNELS-1:0]        pix_ok_q, pix_ok_d;
  logic                       beat_vld_q, clr_s2_q;
  logic [COLOR_W-1:0]         prev_r_q, prev_r_d;
  logic                       seed_q, seed_d, seed_eff;
  logic [COLOR_W-1:0]         ramp_base;
  // stage 3
  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic                       sticky_q, sticky_d;
  logic                       beat_good, counted_bad, exit_now;

  logic [COLOR_W-1:0]         r_c [CHANNELS];
  logic [COLOR_W-1:0]         g_c [CHANNELS];
  logic [COLOR_W-1:0]         b_c [CHANNELS];
  logic [PIX_W-1:0]           pix_c [CHANNELS];
  logic [CHANNELS-1:0]        gray_c;

  // Input register; mode and reference only move on the frame-start pulse.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      clr_s1_q <= 1'b0;
      rgb_s1_q <= '0;
      mode_q   <= MODE_GRAY;
      ref_q    <= '0;
    end else begin
      de_s1_q  <= I_de;
      vs_s1_q  <= I_vs;
      clr_s1_q <= I_clr;
      rgb_s1_q <= I_rgb_data;
      if (I_vs) begin
        mode_q <= I_mode;
        ref_q  <= I_ref_rgb;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign pix_c[c]  = rgb_s1_q[c*PIX_W +: PIX_W];
    assign r_c[c]    = rgb_s1_q[c*PIX_W + 2*COLOR_W +: COLOR_W];
    assign g_c[c]    = rgb_s1_q[c*PIX_W + COLOR_W +: COLOR_W];
    assign b_c[c]    = rgb_s1_q[c*PIX_W +: COLOR_W];
    assign gray_c[c] = (r_c[c] == g_c[c]) && (g_c[c] == b_c[c]);
  end

  // A beat is a ramp seed after reset, on I_vs, or when the beat ahead of it just dropped lock.
  assign seed_eff  = seed_q | vs_s1_q | exit_now;
  assign ramp_base = seed_eff ? r_c[0] : prev_r_q + COLOR_W'(CHANNELS);

  // Per-channel pattern compare; channel 0 carries the inter-beat continuity check.
  always_comb begin
    pix_ok_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_q)
        MODE_FIXED: pix_ok_d[c] = (pix_c[c] == ref_q);
        MODE_RAMP:  pix_ok_d[c] = gray_c[c] &&
                                  (r_c[c] == ((c == 0) ? ramp_base : r_c[0] + COLOR_W'(c)));
        default:    pix_ok_d[c] = gray_c[c];
      endcase
    end
    if (!de_s1_q) pix_ok_d = '0;
    prev_r_d = de_s1_q ? r_c[0] : prev_r_q;
    seed_d   = de_s1_q ? 1'b0 : seed_eff;
  end

  // Compare result register plus ramp history.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pix_ok_q   <= '0;
      beat_vld_q <= 1'b0;
      clr_s2_q   <= 1'b0;
      prev_r_q   <= '0;
      seed_q     <= 1'b1;
    end else begin
      pix_ok_q   <= pix_ok_d;
      beat_vld_q <= de_s1_q;
      clr_s2_q   <= clr_s1_q;
      prev_r_q   <= prev_r_d;
      seed_q     <= seed_d;
    end
  end

  // Lock FSM next state; idle cycles leave the run counter untouched.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    counted_bad = 1'b0;
    exit_now    = 1'b0;
    beat_good   = &pix_ok_q;
    case (state_q)
      ST_SEARCH: begin
        if (beat_vld_q) begin
          if (!beat_good) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(LOCK_GOOD - 1)) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (beat_vld_q) begin
          if (beat_good) begin
            cnt_d = '0;
          end else begin
            counted_bad = 1'b1;
            if (cnt_q == CNT_W'(LOCK_BAD - 1)) begin
              state_d  = ST_SEARCH;
              cnt_d    = '0;
              exit_now = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
        cnt_d   = '0;
      end
    endcase
  end

  // Error statistics next state; clear beats a simultaneous counted bad beat.
  always_comb begin
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q | counted_bad;
    if (counted_bad && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    if (clr_s2_q) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end
  end

  // FSM and statistics registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_SEARCH;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

`ifdef RGB_CHK_FRAME_STAT_EN
  logic vs_s2_q;
  logic frame_bad_q, frame_bad_d;
  logic frame_err_q, frame_err_d;

  // Frame boundary reports the closing frame; a bad vs beat belongs to the new frame.
  always_comb begin
    frame_err_d = 1'b0;
    frame_bad_d = frame_bad_q | counted_bad;
    if (vs_s2_q) begin
      frame_err_d = frame_bad_q;
      frame_bad_d = counted_bad;
    end
  end

  // Frame tracking registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_s2_q     <= 1'b0;
      frame_bad_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vs_s2_q     <= vs_s1_q;
      frame_bad_q <= frame_bad_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign O_frame_err = frame_err_q;
`else
  assign O_frame_err = 1'b0;
`endif

  assign O_pix_ok     = pix_ok_q;
  assign O_beat_vld   = beat_vld_q;
  assign O_lock       = (state_q == ST_LOCKED);
  assign O_err_cnt    = err_cnt_q;
  assign O_sticky_err = sticky_q;

endmodule

// File: tb/tb_rgb_pattern_checker.sv
// Directed bench for rgb_pattern_checker: two instances share stimulus, one with a 16-bit
// error counter and one with a 2-bit counter to exercise saturation.
module tb_rgb_pattern_checker;

  typedef struct {
    logic        vs;
    logic        de;
    logic        clr;
    logic [1:0]  mode;
    logic [23:0] ref_rgb;
    logic [47:0] rgb;
    logic [1:0]  ok;
    logic        lock;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        sticky;
    logic        ferr;
  } vec_t;

`ifdef RGB_CHK_FRAME_STAT_EN
  localparam bit FSTAT = 1'b1;
`else
  localparam bit FSTAT = 1'b0;
`endif

  localparam logic [47:0] G55 = {24'h555555, 24'h555555};
  localparam logic [47:0] F12 = {24'h123456, 24'h123456};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0, de = 1'b0, clr = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] ref_rgb = '0;
  logic [47:0] rgb = '0;

  logic [1:0]  pix_ok_a, pix_ok_b;
  logic        vld_a, vld_b, lock_a, lock_b, sticky_a, sticky_b, ferr_a, ferr_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  vec_t        tbl[$];
  vec_t        idle;
  logic        e_lock;
  logic [15:0] e_cnt;
  logic [1:0]  e_cnt2;
  logic        e_sticky;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rgb_pattern_checker #(.CHANNELS(2), .COLOR_W(8), .ERR_CNT_W(16), .LOCK_GOOD(16), .LOCK_BAD(4)) dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_de(de), .I_mode(mode), .I_ref_rgb(ref_rgb),
    .I_clr(clr), .I_rgb_data(rgb), .O_pix_ok(pix_ok_a), .O_beat_vld(vld_a), .O_lock(lock_a),
    .O_err_cnt(cnt_a), .O_sticky_err(sticky_a), .O_frame_err(ferr_a));

  rgb_pattern_checker #(.CHANNELS(2), .COLOR_W(8), .ERR_CNT_W(2), .LOCK_GOOD(16), .LOCK_BAD(4)) dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_de(de), .I_mode(mode), .I_ref_rgb(ref_rgb),
    .I_clr(clr), .I_rgb_data(rgb), .O_pix_ok(pix_ok_b), .O_beat_vld(vld_b), .O_lock(lock_b),
    .O_err_cnt(cnt_b), .O_sticky_err(sticky_b), .O_frame_err(ferr_b));

  task automatic add(input logic vs_i, input logic de_i, input logic clr_i, input logic [1:0] mode_i,
                     input logic [23:0] ref_i, input logic [47:0] rgb_i, input logic [1:0] ok_i,
                     input logic ferr_i);
    vec_t v;
    v.vs = vs_i; v.de = de_i; v.clr = clr_i; v.mode = mode_i; v.ref_rgb = ref_i; v.rgb = rgb_i;
    v.ok = ok_i; v.lock = e_lock; v.cnt = e_cnt; v.cnt2 = e_cnt2; v.sticky = e_sticky; v.ferr = ferr_i;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    vs = v.vs; de = v.de; clr = v.clr; mode = v.mode; ref_rgb = v.ref_rgb; rgb = v.rgb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle = '{vs: 1'b0, de: 1'b0, clr: 1'b0, mode: 2'd0, ref_rgb: 24'h0, rgb: 48'h0,
             ok: 2'b00, lock: 1'b0, cnt: 16'h0, cnt2: 2'b0, sticky: 1'b0, ferr: 1'b0};
    e_lock = 1'b0; e_cnt = '0; e_cnt2 = '0; e_sticky = 1'b0;

    // gray frame: 20 good beats, lock after the 16th
    for (int j = 0; j < 20; j++) begin
      e_lock = (j >= 15);
      add(j == 0, 1'b1, 1'b0, 2'd0, 24'h0, G55, 2'b11, 1'b0);
    end
    e_cnt = 1; e_cnt2 = 1; e_sticky = 1'b1;
    add(1'b0, 1'b1, 1'b0, 2'd0, 24'h0, {24'h555455, 24'h555555}, 2'b01, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 48'h0, 2'b00, 1'b0);
    // ramp frame with wrap, one continuity error, then four bad beats dropping lock
    add(1'b1, 1'b1, 1'b0, 2'd1, 24'h0, {24'hFFFFFF, 24'hFEFEFE}, 2'b11, 1'b1);
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h010101, 24'h000000}, 2'b11, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h030303, 24'h020202}, 2'b11, 1'b0);
    e_cnt = 2; e_cnt2 = 2;
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h060606, 24'h050505}, 2'b10, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h080808, 24'h070707}, 2'b11, 1'b0);
    e_cnt = 3; e_cnt2 = 3;
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h0A0B0A, 24'h090909}, 2'b01, 1'b0);
    e_cnt = 4;
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h0C0D0C, 24'h0B0B0B}, 2'b01, 1'b0);
    e_cnt = 5;
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h0E0F0E, 24'h0D0D0D}, 2'b01, 1'b0);
    e_cnt = 6; e_lock = 1'b0;
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h101110, 24'h0F0F0F}, 2'b01, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h414141, 24'h404040}, 2'b11, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'd1, 24'h0, {24'h434343, 24'h424242}, 2'b11, 1'b0);
    // fixed frame: reference latched on vs only, relock, clear racing a bad beat
    add(1'b1, 1'b1, 1'b0, 2'd2, 24'h123456, F12, 2'b11, 1'b1);
    for (int k = 0; k < 14; k++) begin
      e_lock = (k >= 12);
      add(1'b0, 1'b1, 1'b0, 2'd0, 24'hABCDEF, F12, 2'b11, 1'b0);
    end
    e_cnt = 0; e_cnt2 = 0; e_sticky = 1'b0;
    add(1'b0, 1'b1, 1'b1, 2'd0, 24'hABCDEF, {24'h123457, 24'h123456}, 2'b01, 1'b0);
    e_cnt = 1; e_cnt2 = 1; e_sticky = 1'b1;
    add(1'b0, 1'b1, 1'b0, 2'd0, 24'hABCDEF, {24'h123456, 24'h000000}, 2'b10, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'd0, 24'hABCDEF, F12, 2'b11, 1'b0);
    // clean gray frame, then reserved mode behaves as gray
    add(1'b1, 1'b1, 1'b0, 2'd0, 24'h0, G55, 2'b11, 1'b1);
    add(1'b0, 1'b1, 1'b0, 2'd0, 24'h0, G55, 2'b11, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'd3, 24'h0, {24'h101010, 24'h777777}, 2'b11, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'd3, 24'h0, {24'h777777, 24'h777777}, 2'b11, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'd3, 24'h0, {24'h777777, 24'h777777}, 2'b11, 1'b0);

    // reset state
    drive(idle);
    repeat (3) step();
    chk("rst_pix_ok", -1, 32'(pix_ok_a), 32'h0);
    chk("rst_vld", -1, 32'(vld_a), 32'h0);
    chk("rst_lock", -1, 32'(lock_a), 32'h0);
    chk("rst_cnt_a", -1, 32'(cnt_a), 32'h0);
    chk("rst_cnt_b", -1, 32'(cnt_b), 32'h0);
    chk("rst_sticky", -1, 32'(sticky_a), 32'h0);
    chk("rst_ferr", -1, 32'(ferr_a), 32'h0);
    rst_n = 1'b1;

    // table run: pix results trail by one step, FSM/statistics by two
    for (int i = 0; i < tbl.size() + 2; i++) begin
      if (i < tbl.size()) drive(tbl[i]);
      else drive(idle);
      step();
      if (i >= 1) begin
        chk("beat_vld_a", i - 1, 32'(vld_a), 32'(tbl[i-1].de));
        chk("beat_vld_b", i - 1, 32'(vld_b), 32'(tbl[i-1].de));
        chk("pix_ok_a", i - 1, 32'(pix_ok_a), 32'(tbl[i-1].ok));
        chk("pix_ok_b", i - 1, 32'(pix_ok_b), 32'(tbl[i-1].ok));
      end
      if (i >= 2) begin
        chk("lock_a", i - 2, 32'(lock_a), 32'(tbl[i-2].lock));
        chk("lock_b", i - 2, 32'(lock_b), 32'(tbl[i-2].lock));
        chk("err_cnt_a", i - 2, 32'(cnt_a), 32'(tbl[i-2].cnt));
        chk("err_cnt_b", i - 2, 32'(cnt_b), 32'(tbl[i-2].cnt2));
        chk("sticky_a", i - 2, 32'(sticky_a), 32'(tbl[i-2].sticky));
        chk("sticky_b", i - 2, 32'(sticky_b), 32'(tbl[i-2].sticky));
        chk("frame_err_a", i - 2, 32'(ferr_a), 32'(FSTAT & tbl[i-2].ferr));
        chk("frame_err_b", i - 2, 32'(ferr_b), 32'(FSTAT & tbl[i-2].ferr));
      end
    end

    // reset asserted mid-frame clears everything without waiting for a clock edge
    vs = 1'b0; de = 1'b1; clr = 1'b0; mode = 2'd0; rgb = G55;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", -2, 32'(vld_a), 32'h0);
    chk("async_rst_lock", -2, 32'(lock_a), 32'h0);
    chk("async_rst_cnt", -2, 32'(cnt_a), 32'h0);
    chk("async_rst_sticky", -2, 32'(sticky_a), 32'h0);
    chk("async_rst_cnt_b", -2, 32'(cnt_b), 32'h0);
    drive(idle);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_lock", -3, 32'(lock_b), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
